cnn_layer_sequencer: RTL and testbench

//  Sequences one CNN_Processor layer per job. Streams kernel weights, bias and image from a

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/cnn_watchdog.sv | 32 +++
 rtl/cnn_layer_sequencer.sv | 134 +++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and state type for the CNN layer sequencer; values mirror the
// CNN_Processor header so the load/read ports line up.
package cnn_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int IMG_SIZE       = 64;
  localparam int KERNEL_AREA    = 9;
  localparam int POOL_OUT_AREA  = 9;
  localparam int IMG_ADDR_W     = 6;
  localparam int POOL_ADDR_W    = 4;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int JOB_COUNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KERN,
    LOAD_IMG,
    START,
    WAIT,
    DRAIN
  } seq_state_t;

  function automatic logic is_load_state(input seq_state_t s);
    return (s == LOAD_KERN) || (s == LOAD_IMG);
  endfunction

endpackage

// File: rtl/cnn_watchdog.sv
// Cycle watchdog: cleared by load, counts while enabled, expire is high on the
// TIMEOUT_CYCLES-th enabled cycle.
module cnn_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs one CNN_Processor layer per job: streams kernel/bias/image into the load
// port, pulses start, waits for done (with watchdog), then drains the pooled map.
module cnn_layer_sequencer
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic                    job_reload_kern,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [JOB_COUNT_W-1:0]  job_count,
  output logic                    cnn_start,
  input  logic                    cnn_done,
  output logic                    cnn_wr_en,
  output logic                    cnn_mem_select,
  output logic [IMG_ADDR_W-1:0]   cnn_wr_addr,
  output logic [DATA_WIDTH-1:0]   cnn_data_in,
  output logic [POOL_ADDR_W-1:0]  cnn_rd_addr,
  input  logic [DATA_WIDTH-1:0]   cnn_data_out
);

  localparam logic [IMG_ADDR_W-1:0]  KERN_LAST  = IMG_ADDR_W'(KERNEL_AREA);
  localparam logic [IMG_ADDR_W-1:0]  IMG_LAST   = IMG_ADDR_W'(IMG_SIZE - 1);
  localparam logic [POOL_ADDR_W-1:0] DRAIN_LAST = POOL_ADDR_W'(POOL_OUT_AREA - 1);

  seq_state_t state, state_nxt;

  logic [IMG_ADDR_W-1:0]  word_cnt;
  logic [POOL_ADDR_W-1:0] drain_cnt;
  logic job_hs, in_hs, out_hs;
  logic load_last, drain_last;
  logic wd_expire, timeout_hit;

  assign job_hs      = job_valid && job_ready;
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign load_last   = (state == LOAD_KERN) ? (word_cnt == KERN_LAST) : (word_cnt == IMG_LAST);
  assign drain_last  = (drain_cnt == DRAIN_LAST);
  assign timeout_hit = (state == WAIT) && !cnn_done && wd_expire;
  assign cnn_rd_addr = drain_cnt;

  cnn_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == START),
    .enable(state == WAIT),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (job_valid) state_nxt = job_reload_kern ? LOAD_KERN : LOAD_IMG;
      LOAD_KERN: if (in_valid && load_last) state_nxt = LOAD_IMG;
      LOAD_IMG:  if (in_valid && load_last) state_nxt = START;
      START:     state_nxt = WAIT;
      WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (cnn_done)       state_nxt = DRAIN;
        else if (wd_expire) state_nxt = IDLE;
      end
      DRAIN:     if (out_ready && drain_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state == IDLE);
    in_ready  = is_load_state(state);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_last  = out_valid && drain_last;
    out_data  = out_valid ? cnn_data_out : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt       <= '0;
      drain_cnt      <= '0;
      cnn_wr_en      <= 1'b0;
      cnn_mem_select <= 1'b0;
      cnn_wr_addr    <= '0;
      cnn_data_in    <= '0;
      cnn_start      <= 1'b0;
      err_timeout    <= 1'b0;
      job_count      <= '0;
    end else begin
      cnn_wr_en <= in_hs;

      if (job_hs) begin
        word_cnt    <= '0;
        drain_cnt   <= '0;
        err_timeout <= 1'b0;
      end

      // The write lands one cycle after the handshake; the last image word
      // commits during START, before the processor reads the image.
      if (in_hs) begin
        cnn_mem_select <= (state == LOAD_KERN);
        cnn_wr_addr    <= word_cnt;
        cnn_data_in    <= in_data;
        word_cnt       <= load_last ? '0 : word_cnt + 1'b1;
      end

      // Held until done is seen; dropping it releases the processor from FINISH.
      cnn_start <= (state == START) || ((state == WAIT) && !cnn_done && !wd_expire);

      if (timeout_hit) err_timeout <= 1'b1;

      if (out_hs) begin
        drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
        if (drain_last) job_count <= job_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: behavioural CNN_Processor model, randomized jobs,
// scoreboard of expected pooled outputs computed from the stimulus arrays.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic job_valid, job_ready, job_reload_kern;
  logic in_valid, in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic busy, err_timeout;
  logic [JOB_COUNT_W-1:0] job_count;
  logic cnn_start, cnn_done, cnn_wr_en, cnn_mem_select;
  logic [IMG_ADDR_W-1:0]  cnn_wr_addr;
  logic [DATA_WIDTH-1:0]  cnn_data_in;
  logic [POOL_ADDR_W-1:0] cnn_rd_addr;
  logic [DATA_WIDTH-1:0]  cnn_data_out;

  always #5 clk = ~clk;

  cnn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_reload_kern(job_reload_kern),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout), .job_count(job_count),
    .cnn_start(cnn_start), .cnn_done(cnn_done), .cnn_wr_en(cnn_wr_en),
    .cnn_mem_select(cnn_mem_select), .cnn_wr_addr(cnn_wr_addr), .cnn_data_in(cnn_data_in),
    .cnn_rd_addr(cnn_rd_addr), .cnn_data_out(cnn_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference: valid 3x3 conv + bias on 8x8, ReLU, 2x2 max-pool -> 3x3.
  function automatic void compute(input logic signed [7:0] k [10],
                                  input logic signed [7:0] im [64],
                                  output logic [7:0] r [9]);
    for (int pr = 0; pr < 3; pr++) begin
      for (int pc = 0; pc < 3; pc++) begin
        int best;
        best = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int acc;
            acc = int'(k[9]);
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                acc += int'(k[i*3+j]) * int'(im[(2*pr+dy+i)*8 + 2*pc+dx+j]);
            if (acc > best) best = acc;
          end
        end
        if (best > 127) best = 127;
        r[pr*3+pc] = 8'(best);
      end
    end
  endfunction

  // Processor model: memories fed by the DUT's load port, done after a random latency.
  logic signed [7:0] p_kern [10];
  logic signed [7:0] p_img  [64];
  logic [7:0] p_res [9];
  logic [7:0] p_tmp [9];
  int  p_kern_wr = 0;
  int  p_lat;
  bit  p_busy;
  bit  stub_never_done = 1'b0;

  initial for (int i = 0; i < 9; i++) p_res[i] = 8'h00;

  assign cnn_data_out = (cnn_rd_addr < 4'd9) ? p_res[cnn_rd_addr] : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnn_done <= 1'b0;
      p_busy   <= 1'b0;
      p_lat    <= 0;
    end else begin
      if (cnn_wr_en) begin
        if (cnn_mem_select) begin
          if (cnn_wr_addr <= 6'd9) p_kern[cnn_wr_addr] <= cnn_data_in;
          p_kern_wr <= p_kern_wr + 1;
        end else begin
          p_img[cnn_wr_addr] <= cnn_data_in;
        end
      end
      if (!cnn_start) begin
        cnn_done <= 1'b0;
        p_busy   <= 1'b0;
      end else if (!p_busy && !cnn_done) begin
        p_busy <= 1'b1;
        p_lat  <= int'($urandom_range(4, 20));
      end else if (p_busy) begin
        if (p_lat != 0) begin
          p_lat <= p_lat - 1;
        end else if (!stub_never_done) begin
          compute(p_kern, p_img, p_tmp);
          p_res    <= p_tmp;
          cnn_done <= 1'b1;
          p_busy   <= 1'b0;
        end
      end
    end
  end

  // Scoreboard: {out_last, out_data} per expected word.
  logic [8:0] exp_q [$];
  int  bp_mode = 0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h with no word expected", out_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_word", 32'({out_last, out_data}), 32'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  logic signed [7:0] stim_kern [10];
  logic signed [7:0] stim_img  [64];
  logic signed [7:0] ref_kern  [10];
  int exp_jobs = 0;

  localparam int MODE_NORMAL  = 0;
  localparam int MODE_TIMEOUT = 1;
  localparam int MODE_ABORT   = 2;

  task automatic set_uniform(input logic [7:0] w, input logic [7:0] b, input logic [7:0] px);
    for (int i = 0; i < 9; i++) stim_kern[i] = w;
    stim_kern[9] = b;
    for (int i = 0; i < 64; i++) stim_img[i] = px;
  endtask

  task automatic set_random();
    for (int i = 0; i < 9; i++) stim_kern[i] = 8'($urandom_range(0, 4)) - 8'd2;
    stim_kern[9] = 8'($urandom_range(0, 16)) - 8'd8;
    for (int i = 0; i < 64; i++) stim_img[i] = 8'($urandom_range(0, 3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, 32'(job_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_cnn_start"}, 32'(cnn_start), 32'd0);
    check({tag, "_cnn_wr_en"}, 32'(cnn_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(cnn_wr_addr), 32'd0);
    check({tag, "_rd_addr"}, 32'(cnn_rd_addr), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_job_count"}, 32'(job_count), 32'd0);
  endtask

  task automatic run_job(input bit reload, input int gap_pct, input int mode, input int abort_img);
    logic [7:0] words [$];
    logic [7:0] res [9];
    int guard, idx, kw0, stop_at, start_cycles;
    if (reload) ref_kern = stim_kern;
    compute(ref_kern, stim_img, res);
    if (reload) for (int i = 0; i < 10; i++) words.push_back(stim_kern[i]);
    for (int i = 0; i < 64; i++) words.push_back(stim_img[i]);
    stop_at = (mode == MODE_ABORT) ? (reload ? 10 : 0) + abort_img : words.size();

    @(negedge clk);
    job_valid = 1'b1;
    job_reload_kern = reload;
    #1;
    guard = 0;
    while (!job_ready && guard < 100) begin
      guard++;
      @(negedge clk);
      #1;
    end
    if (!job_ready) begin
      fail_bound("job_accept");
      job_valid = 1'b0;
      return;
    end
    if (mode == MODE_NORMAL)
      for (int i = 0; i < 9; i++) exp_q.push_back({i == 8, res[i]});
    @(negedge clk);
    job_valid = 1'b0;
    kw0 = p_kern_wr;
    check("err_clear_on_job", 32'(err_timeout), 32'd0);
    check("busy_in_job", 32'(busy), 32'd1);

    idx = 0;
    guard = 0;
    while (idx < stop_at && guard < 2000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = words[idx];
      #1;
      if (in_valid && in_ready) idx++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (idx < stop_at) begin
      fail_bound("load_stream");
      return;
    end
    if (mode == MODE_ABORT) return;

    guard = 0;
    if (mode == MODE_TIMEOUT) begin
      start_cycles = 0;
      while (!job_ready && guard < 1500) begin
        if (cnn_start) start_cycles++;
        guard++;
        @(negedge clk);
      end
      if (!job_ready) fail_bound("timeout_return");
      check("timeout_wait_cycles", 32'(start_cycles), 32'd1024);
      check("timeout_err", 32'(err_timeout), 32'd1);
      check("timeout_start_low", 32'(cnn_start), 32'd0);
      check("timeout_job_count", 32'(job_count), 32'(exp_jobs));
    end else begin
      while (!(job_ready && exp_q.size() == 0) && guard < 3000) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 3000) fail_bound("job_complete");
      exp_jobs++;
      check("job_count", 32'(job_count), 32'(exp_jobs));
      check("kernel_writes", 32'(p_kern_wr - kw0), reload ? 32'd10 : 32'd0);
      check("err_after_job", 32'(err_timeout), 32'd0);
      check("start_low_idle", 32'(cnn_start), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_reload_kern = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    for (int i = 0; i < 10; i++) ref_kern[i] = 8'sd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Scenario 1: unit kernel, zero bias, unit image -> all nines.
    bp_mode = 0;
    set_uniform(8'd1, 8'd0, 8'd1);
    run_job(1'b1, 0, MODE_NORMAL, 0);

    // Scenario 2: keep kernel, image of twos -> all eighteens.
    set_uniform(8'd1, 8'd0, 8'd2);
    run_job(1'b0, 0, MODE_NORMAL, 0);

    // Scenario 3: negative bias drives every output through ReLU to zero.
    set_uniform(8'd1, 8'hF6, 8'd1);
    run_job(1'b1, 0, MODE_NORMAL, 0);

    // Scenario 4: scenario 1 under output backpressure and input gaps.
    bp_mode = 1;
    set_uniform(8'd1, 8'd0, 8'd1);
    run_job(1'b1, 30, MODE_NORMAL, 0);

    // Randomized jobs.
    for (int r = 0; r < 6; r++) begin
      bp_mode = int'($urandom_range(0, 2));
      set_random();
      run_job((r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
              MODE_NORMAL, 0);
    end

    // Watchdog: processor never finishes.
    bp_mode = 0;
    stub_never_done = 1'b1;
    set_random();
    run_job(1'b1, 0, MODE_TIMEOUT, 0);
    stub_never_done = 1'b0;
    set_random();
    run_job(1'b0, 10, MODE_NORMAL, 0);

    // Reset in the middle of the image load.
    set_uniform(8'd1, 8'd0, 8'd1);
    run_job(1'b1, 0, MODE_ABORT, 30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_job_reset");
    exp_jobs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b1, 0, MODE_NORMAL, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
